fg_config_writer: RTL
=====================

Name: fg_config_writer

Overview:
- Host-side initiator for the function generator's parallel configuration-register write interface.
- Accepts a 56-bit configuration word and a per-register write mask.
- Sequences timed writes (data, address, write strobe, enable pin) so that the target's 2-stage synchronized, level-sensitive register file captures each byte exactly.
- Used in on-board controllers and as the stimulus driver in top-level benches.

Parameters:
- NUM_REGS, 7: number of 8-bit config registers (CR0..CR6).
- DATA_WIDTH, 8: register width.
- ADDR_WIDTH, 3: register address width.
- SETUP_CYCLES, 2: cycles addr/data are stable before the strobe asserts (>=1).
- STROBE_CYCLES, 4: cycles wr_n_o is held low (>=1).
- HOLD_CYCLES, 3: cycles addr/data are held after the strobe releases; also the settle time after disabling (>= SYNC_STAGES+1 = 3).
- CNT_WIDTH, 4: timing counter width; must hold max(SETUP, STROBE, HOLD).

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- start_i  in  1  single-cycle request; sampled only in IDLE
- cfg_i  in  NUM_REGS*DATA_WIDTH  config word; CR0 in [55:48] down to CR6 in [7:0]
- mask_i  in  NUM_REGS  bit i=1 means CRi is written
- run_i  in  1  level; 1 = generator should run when the writer is idle
- wr_data_o  out  DATA_WIDTH  to target data inputs
- wr_addr_o  out  ADDR_WIDTH  to target address inputs
- wr_n_o  out  1  write enable, active low
- en_n_o  out  1  target enable pin, active low (1 = generator stopped, writes allowed)
- busy_o  out  1  sequence in progress
- done_o  out  1  one-cycle pulse at sequence end

Behaviour:
- Reset (async, immediate, including mid-sequence):
  - wr_data_o=0, wr_addr_o=0, wr_n_o=1, en_n_o=1, busy_o=0, done_o=0, state IDLE.
  - Internal cfg/mask latches and counters are cleared.
- States: IDLE, SETTLE, SETUP, STROBE, HOLD, DONE.
- IDLE:
  - en_n_o <= !run_i (registered, 1-cycle lag). wr_n_o=1.
  - On start_i: latch cfg_i and mask_i.
    - If the latched mask is 0: go to DONE without bus activity; en_n_o keeps tracking run_i.
    - Otherwise: go to SETTLE.
- SETTLE:
  - en_n_o=1, busy_o=1, held for HOLD_CYCLES cycles.
  - Exit: select the lowest set mask index i, drive wr_addr_o=i and wr_data_o=CRi, go to SETUP.
- SETUP: SETUP_CYCLES cycles, wr_n_o=1, then go to STROBE.
- STROBE: STROBE_CYCLES cycles, wr_n_o=0, addr/data unchanged, then go to HOLD.
- HOLD: HOLD_CYCLES cycles, wr_n_o=1, addr/data unchanged.
  - Exit: clear mask bit i. If any mask bit remains, load the next lowest index and go to SETUP; otherwise go to DONE.
- DONE:
  - One cycle: done_o=1, busy_o=0. Return to IDLE.
  - en_n_o returns to !run_i on the following cycle.
- Invariants:
  - wr_addr_o/wr_data_o change only on the SETTLE->SETUP or HOLD->SETUP transition, never while wr_n_o=0 or in HOLD.
  - en_n_o=1 for the whole interval busy_o=1.
- Timing:
  - busy_o is high for exactly HOLD_CYCLES + N*(SETUP_CYCLES+STROBE_CYCLES+HOLD_CYCLES) cycles, where N = popcount(mask).
  - With defaults and all 7 registers: 3 + 7*9 = 66 cycles.
- start_i while busy or in DONE is ignored (no queuing). Changes to cfg_i/mask_i after the start cycle have no effect.
- run_i changes during a sequence take effect only after DONE.
- Addresses 7 and up are never driven.

Decomposition:
- Shared package (fg_pkg): state encoding constants, NUM_REGS/DATA_WIDTH/ADDR_WIDTH, sync-stage count, and the CR index to cfg bit-slice mapping. The register file in the top level uses the same package.
- One natural sub-module: fg_priority_select, a combinational lowest-set-bit encoder over the mask (index + valid).
- The timing down-counter stays inline.

Test Plan:
- Reset: hold rstn_i=0 -> all outputs at reset values. Release with run_i=0 -> en_n_o stays 1 and wr_n_o stays 1.
- Full write: cfg=0x54_10_00_00_00_32_80, mask=7'h7F, start -> seven strobes, addr 0..6 in order, data 54,10,00,00,00,32,80. Each strobe low 4 cycles with data stable 2 cycles before and 3 after. busy_o high 66 cycles, then done_o for 1 cycle. In the loopback top-level bench, CR0..CR6 read back equal cfg.
- Partial mask: mask=7'b0100001, cfg CR0=0xAA, CR5=0x5C -> exactly two strobes (addr 0 data AA, addr 5 data 5C). busy_o high 3+18=21 cycles. Other registers unchanged.
- Mask zero: mask=0, start -> done_o pulses the cycle after start, busy_o never rises, wr_n_o stays 1, en_n_o keeps tracking run_i.
- Busy/run interaction: run_i=1 (en_n_o=0), then start -> en_n_o=1 the next cycle. Extra start pulses mid-sequence are ignored (strobe count unchanged). en_n_o=0 one cycle after done_o.
- Reset mid-strobe: assert rstn_i while wr_n_o=0 -> wr_n_o=1 and en_n_o=1 immediately (same cycle, async). After release the state is IDLE and no further strobes occur.

Source files
------------

// File: rtl/fg_pkg.sv
// Shared constants, state encoding and config-word layout for the function
// generator configuration-register interface.
package fg_pkg;

   localparam int NUM_REGS    = 7;
   localparam int DATA_WIDTH  = 8;
   localparam int ADDR_WIDTH  = 3;
   localparam int SYNC_STAGES = 2;
   localparam int CFG_WIDTH   = NUM_REGS * DATA_WIDTH;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_SETUP  = 3'd2,
      ST_STROBE = 3'd3,
      ST_HOLD   = 3'd4,
      ST_DONE   = 3'd5
   } fg_state_t;

   // CR0 occupies the most significant byte of the config word, CR6 the least.
   function automatic logic [DATA_WIDTH-1:0] cr_byte(input logic [CFG_WIDTH-1:0]  cfg,
                                                      input logic [ADDR_WIDTH-1:0] idx);
      return cfg[(NUM_REGS - 1 - int'(idx)) * DATA_WIDTH +: DATA_WIDTH];
   endfunction

endpackage

// File: rtl/fg_priority_select.sv
// Lowest-set-bit encoder: returns the index of the lowest set mask bit and
// whether any bit is set at all.
module fg_priority_select #(
   parameter int N = 7,
   parameter int W = 3
) (
   input  logic [N-1:0] mask_i,
   output logic [W-1:0] idx_o,
   output logic         valid_o
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      idx_o = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (mask_i[i]) begin
            idx_o = W'(i);
         end
      end
   end

   assign valid_o = |mask_i;

endmodule

// File: rtl/fg_config_writer.sv
// Host-side sequencer that writes masked bytes of a config word into the
// generator's level-sensitive register file with setup/strobe/hold timing.
module fg_config_writer
   import fg_pkg::*;
#(
   parameter int SETUP_CYCLES  = 2,
   parameter int STROBE_CYCLES = 4,
   parameter int HOLD_CYCLES   = 3,
   parameter int CNT_WIDTH     = 4
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  start_i,
   input  logic [CFG_WIDTH-1:0]  cfg_i,
   input  logic [NUM_REGS-1:0]   mask_i,
   input  logic                  run_i,
   output logic [DATA_WIDTH-1:0] wr_data_o,
   output logic [ADDR_WIDTH-1:0] wr_addr_o,
   output logic                  wr_n_o,
   output logic                  en_n_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam logic [CNT_WIDTH-1:0] SETUP_LOAD  = CNT_WIDTH'(SETUP_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] STROBE_LOAD = CNT_WIDTH'(STROBE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] HOLD_LOAD   = CNT_WIDTH'(HOLD_CYCLES - 1);

   fg_state_t             state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [CFG_WIDTH-1:0]  cfg_q, cfg_d;
   logic [NUM_REGS-1:0]   mask_q, mask_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic                  wr_n_q, wr_n_d;
   logic                  en_n_q, en_n_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic [ADDR_WIDTH-1:0] sel_idx;
   logic                  sel_valid;

   // mask_q holds only the registers still to be written; the bit of the
   // register on the bus is dropped when it is loaded.
   fg_priority_select #(
      .N (NUM_REGS),
      .W (ADDR_WIDTH)
   ) u_select (
      .mask_i  (mask_q),
      .idx_o   (sel_idx),
      .valid_o (sel_valid)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cfg_d     = cfg_q;
      mask_d    = mask_q;
      wr_data_d = wr_data_q;
      wr_addr_d = wr_addr_q;
      en_n_d    = 1'b1;

      case (state_q)
         ST_IDLE: begin
            en_n_d = !run_i;
            if (start_i) begin
               cfg_d  = cfg_i;
               mask_d = mask_i;
               if (mask_i == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_SETTLE;
                  cnt_d   = HOLD_LOAD;
                  en_n_d  = 1'b1;
               end
            end
         end
         ST_SETTLE: begin
            if (cnt_q == '0) begin
               state_d   = ST_SETUP;
               cnt_d     = SETUP_LOAD;
               wr_addr_d = sel_idx;
               wr_data_d = cr_byte(cfg_q, sel_idx);
               mask_d    = mask_q & ~(NUM_REGS'(1) << sel_idx);
            end else begin
               cnt_d = cnt_q - CNT_WIDTH'(1);
            end
         end
         ST_SETUP: begin
            if (cnt_q == '0) begin
               state_d = ST_STROBE;
               cnt_d   = STROBE_LOAD;
            end else begin
               cnt_d = cnt_q - CNT_WIDTH'(1);
            end
         end
         ST_STROBE: begin
            if (cnt_q == '0) begin
               state_d = ST_HOLD;
               cnt_d   = HOLD_LOAD;
            end else begin
               cnt_d = cnt_q - CNT_WIDTH'(1);
            end
         end
         ST_HOLD: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_WIDTH'(1);
            end else if (sel_valid) begin
               state_d   = ST_SETUP;
               cnt_d     = SETUP_LOAD;
               wr_addr_d = sel_idx;
               wr_data_d = cr_byte(cfg_q, sel_idx);
               mask_d    = mask_q & ~(NUM_REGS'(1) << sel_idx);
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            en_n_d  = !run_i;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Status outputs are registered copies of the next state so they line
      // up exactly with state_q and stay glitch-free on the target pins.
      busy_d = (state_d == ST_SETTLE) || (state_d == ST_SETUP) ||
               (state_d == ST_STROBE) || (state_d == ST_HOLD);
      done_d = (state_d == ST_DONE);
      wr_n_d = (state_d != ST_STROBE);
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         cfg_q     <= '0;
         mask_q    <= '0;
         wr_data_q <= '0;
         wr_addr_q <= '0;
         wr_n_q    <= 1'b1;
         en_n_q    <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cfg_q     <= cfg_d;
         mask_q    <= mask_d;
         wr_data_q <= wr_data_d;
         wr_addr_q <= wr_addr_d;
         wr_n_q    <= wr_n_d;
         en_n_q    <= en_n_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign wr_data_o = wr_data_q;
   assign wr_addr_o = wr_addr_q;
   assign wr_n_o    = wr_n_q;
   assign en_n_o    = en_n_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;

endmodule
